tlu_record_fifo: RTL and testbench

- Parametrised record buffer and word serializer in the BUS_CLK domain. It sits between the CDC sync FIFO of the TLU master and the SiTCP/USB 16-bit FIFO readout port.
- Stores whole multi-word trigger records (trigger ID, timestamp, leading edges).
- Serializes records word-by-word on a FIFO_READ interface.
- Adds drop accounting, fill-level reporting and a programmable almost-full flag. The previous fixed 128-bit/8-word readout had none of these.

---
 rtl/tlu_record_fifo.sv | 155 +++++++++++++++
 tb/tb_tlu_record_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tlu_record_fifo.sv
// tlu_record_fifo: record buffer and word serializer for the TLU readout path.
// Whole N_WORDS-word trigger records are stored in a DEPTH-entry ring and
// presented one WORD_WIDTH word at a time on a FIFO_READ style port.
// Records that arrive while the buffer is full are dropped and counted in
// LOST_CNT (saturating). FILL_LEVEL counts stored records, including the
// record currently being read out.
//
// Optional build macro TLU_RECORD_HEADER_EN: every record is preceded by a
// header word {4'hA, SEQ}. SEQ is a record sequence counter that advances
// on each pop.
module tlu_record_fifo #(
    parameter int unsigned N_WORDS    = 8,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                           BUS_CLK,
    input  logic                           RST,
    input  logic [N_WORDS*WORD_WIDTH-1:0]  IN_DATA,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic                           FIFO_READ,
    output logic                           FIFO_EMPTY,
    output logic [WORD_WIDTH-1:0]          FIFO_DATA,
    input  logic [$clog2(DEPTH):0]         CONF_ALMOST_FULL_TH,
    output logic                           ALMOST_FULL,
    output logic [$clog2(DEPTH):0]         FILL_LEVEL,
    output logic [7:0]                     LOST_CNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = N_WORDS * WORD_WIDTH;
`ifdef TLU_RECORD_HEADER_EN
    localparam int unsigned L = N_WORDS + 1;
`else
    localparam int unsigned L = N_WORDS;
`endif
    localparam int unsigned WCW = (L > 1) ? $clog2(L) : 1;

    logic [RW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         fill;
    logic [WCW-1:0]        wcnt;
    logic [7:0]            lost;
    logic [RW-1:0]         head;
    logic [WORD_WIDTH-1:0] word;

    logic in_ready;
    logic empty;
    logic wr_en;
    logic drop;
    logic rd_en;
    logic last_word;
    logic pop;

`ifdef TLU_RECORD_HEADER_EN
    logic [WORD_WIDTH-5:0] seq;
`endif

    // Handshake decode; IN_READY looks only at the registered count, so a
    // pop in the same cycle never frees space for a write while full.
    always_comb begin
        in_ready  = (fill != CW'(DEPTH));
        empty     = (wcnt == '0) && (fill == '0);
        wr_en     = IN_VALID & in_ready;
        drop      = IN_VALID & ~in_ready;
        rd_en     = FIFO_READ & ~empty;
        last_word = (wcnt == WCW'(L - 1));
        pop       = rd_en & last_word;
    end

    // Record storage; no reset needed because the pointers define validity.
    always_ff @(posedge BUS_CLK) begin
        if (!RST && wr_en) begin
            mem[wr_ptr] <= IN_DATA;
        end
    end

    // Pointers, word counter, fill level and saturating drop counter.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            wcnt   <= '0;
            lost   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (drop && (lost != 8'hFF)) begin
                lost <= lost + 8'd1;
            end
            if (rd_en) begin
                wcnt <= last_word ? '0 : wcnt + WCW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

`ifdef TLU_RECORD_HEADER_EN
    // Header sequence number; counts popped records only, so drops leave
    // no gap in the sequence.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            seq <= '0;
        end else if (pop) begin
            seq <= seq + (WORD_WIDTH-4)'(1);
        end
    end
`endif

    assign head = mem[rd_ptr];

    // Output word select from the head record, LSB word first.
    always_comb begin
        word = '0;
`ifdef TLU_RECORD_HEADER_EN
        if (wcnt == '0) begin
            word = {4'hA, seq};
        end else begin
            for (int unsigned k = 0; k < N_WORDS; k++) begin
                if (32'(wcnt) == k + 1) begin
                    word = head[k*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
`else
        for (int unsigned k = 0; k < N_WORDS; k++) begin
            if (32'(wcnt) == k) begin
                word = head[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
`endif
    end

    // Output drive; data forced to zero while nothing is available.
    always_comb begin
        IN_READY    = in_ready;
        FIFO_EMPTY  = empty;
        FIFO_DATA   = empty ? '0 : word;
        FILL_LEVEL  = fill;
        LOST_CNT    = lost;
        ALMOST_FULL = (CONF_ALMOST_FULL_TH != '0) && (fill >= CONF_ALMOST_FULL_TH);
    end

endmodule

// File: tb/tb_tlu_record_fifo.sv
// Directed testbench for tlu_record_fifo with default parameters
// (8 words x 16 bits, 64 records). Follows TLU_RECORD_HEADER_EN if defined.
module tb_tlu_record_fifo;

`ifdef TLU_RECORD_HEADER_EN
    localparam int L = 9;
`else
    localparam int L = 8;
`endif

    logic         BUS_CLK = 1'b0;
    logic         RST = 1'b1;
    logic [127:0] IN_DATA = '0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic         FIFO_READ = 1'b0;
    logic         FIFO_EMPTY;
    logic [15:0]  FIFO_DATA;
    logic [6:0]   CONF_ALMOST_FULL_TH = '0;
    logic         ALMOST_FULL;
    logic [6:0]   FILL_LEVEL;
    logic [7:0]   LOST_CNT;

    int n_cmp = 0;
    int n_err = 0;
    int exp_seq = 0;

    tlu_record_fifo #(
        .N_WORDS    (8),
        .WORD_WIDTH (16),
        .DEPTH      (64)
    ) dut (
        .BUS_CLK             (BUS_CLK),
        .RST                 (RST),
        .IN_DATA             (IN_DATA),
        .IN_VALID            (IN_VALID),
        .IN_READY            (IN_READY),
        .FIFO_READ           (FIFO_READ),
        .FIFO_EMPTY          (FIFO_EMPTY),
        .FIFO_DATA           (FIFO_DATA),
        .CONF_ALMOST_FULL_TH (CONF_ALMOST_FULL_TH),
        .ALMOST_FULL         (ALMOST_FULL),
        .FILL_LEVEL          (FILL_LEVEL),
        .LOST_CNT            (LOST_CNT)
    );

    initial forever #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkrec(input logic [7:0] tag);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = {tag, 8'(k)};
        return r;
    endfunction

    function automatic logic [15:0] exp_word(input logic [127:0] rec, input int j);
`ifdef TLU_RECORD_HEADER_EN
        if (j == 0) return {4'hA, 12'(exp_seq)};
        return rec[(j-1)*16 +: 16];
`else
        return rec[j*16 +: 16];
`endif
    endfunction

    task automatic write_rec(input logic [127:0] rec);
        IN_DATA  = rec;
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
    endtask

    // Reads n words of rec; optionally presents wrec on the last read cycle.
    task automatic read_words(input string tag, input logic [127:0] rec, input int n,
                              input bit wr_last, input logic [127:0] wrec);
        for (int j = 0; j < n; j++) begin
            chk(tag, 32'(FIFO_DATA), 32'(exp_word(rec, j)));
            FIFO_READ = 1'b1;
            if (wr_last && j == n - 1) begin
                IN_DATA  = wrec;
                IN_VALID = 1'b1;
            end
            step();
        end
        FIFO_READ = 1'b0;
        IN_VALID  = 1'b0;
        if (n == L) exp_seq++;
    endtask

    initial begin
        logic [127:0] r1;
        for (int k = 0; k < 8; k++) r1[k*16 +: 16] = 16'(k + 1);

        // Reset held for two cycles
        RST = 1'b1;
        step();
        step();
        chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("rst_ready", 32'(IN_READY), 32'd1);
        chk("rst_fill", 32'(FILL_LEVEL), 32'd0);
        chk("rst_lost", 32'(LOST_CNT), 32'd0);
        chk("rst_data", 32'(FIFO_DATA), 32'd0);
        chk("rst_af", 32'(ALMOST_FULL), 32'd0);
        RST = 1'b0;

        // Reads while empty are ignored
        FIFO_READ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_rd", 32'(FIFO_EMPTY), 32'd1);
            chk("empty_rd_data", 32'(FIFO_DATA), 32'd0);
        end
        FIFO_READ = 1'b0;

        // Single record, words 0x0001..0x0008
        write_rec(r1);
        chk("single_empty", 32'(FIFO_EMPTY), 32'd0);
        chk("single_fill", 32'(FILL_LEVEL), 32'd1);
        read_words("single_data", r1, L, 1'b0, '0);
        chk("single_empty_after", 32'(FIFO_EMPTY), 32'd1);
        chk("single_fill_after", 32'(FILL_LEVEL), 32'd0);

        // Almost-full threshold 4
        CONF_ALMOST_FULL_TH = 7'd4;
        for (int t = 0; t < 3; t++) write_rec(mkrec(8'(t)));
        chk("af_fill3", 32'(FILL_LEVEL), 32'd3);
        chk("af_at3", 32'(ALMOST_FULL), 32'd0);
        write_rec(mkrec(8'd3));
        chk("af_at4", 32'(ALMOST_FULL), 32'd1);

        // Fill to capacity
        for (int t = 4; t < 64; t++) write_rec(mkrec(8'(t)));
        chk("full_fill", 32'(FILL_LEVEL), 32'd64);
        chk("full_ready", 32'(IN_READY), 32'd0);
        chk("full_af", 32'(ALMOST_FULL), 32'd1);
        CONF_ALMOST_FULL_TH = 7'd0;
        #1;
        chk("af_disabled", 32'(ALMOST_FULL), 32'd0);

        // Three drops
        for (int i = 0; i < 3; i++) write_rec(mkrec(8'hEE));
        chk("ovf_lost3", 32'(LOST_CNT), 32'd3);
        chk("ovf_fill", 32'(FILL_LEVEL), 32'd64);

        // Write on the popping cycle while full is still dropped
        read_words("bnd_full_data", mkrec(8'd0), L, 1'b1, mkrec(8'hEE));
        chk("bnd_full_lost", 32'(LOST_CNT), 32'd4);
        chk("bnd_full_fill", 32'(FILL_LEVEL), 32'd63);

        // Refill, then drive total drops to 300
        write_rec(mkrec(8'd64));
        chk("refill_fill", 32'(FILL_LEVEL), 32'd64);
        for (int i = 0; i < 296; i++) write_rec(mkrec(8'hEE));
        chk("lost_sat", 32'(LOST_CNT), 32'd255);
        chk("lost_sat_fill", 32'(FILL_LEVEL), 32'd64);

        // Stored records come back in order
        for (int t = 1; t <= 64; t++) read_words("ovf_order", mkrec(8'(t)), L, 1'b0, '0);
        chk("drain_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("drain_fill", 32'(FILL_LEVEL), 32'd0);

        // Write on the popping cycle at FILL_LEVEL=10 is accepted
        for (int t = 100; t < 110; t++) write_rec(mkrec(8'(t)));
        chk("bnd10_fill", 32'(FILL_LEVEL), 32'd10);
        read_words("bnd10_data", mkrec(8'd100), L, 1'b1, mkrec(8'd110));
        chk("bnd10_fill_after", 32'(FILL_LEVEL), 32'd10);
        for (int t = 101; t <= 110; t++) read_words("bnd10_order", mkrec(8'(t)), L, 1'b0, '0);
        chk("bnd10_empty", 32'(FIFO_EMPTY), 32'd1);

        // Reset in the middle of a record
        write_rec(mkrec(8'h20));
        read_words("mid_a", mkrec(8'h20), 3, 1'b0, '0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_seq = 0;
        chk("mid_rst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("mid_rst_fill", 32'(FILL_LEVEL), 32'd0);
        chk("mid_rst_lost", 32'(LOST_CNT), 32'd0);
        chk("mid_rst_data", 32'(FIFO_DATA), 32'd0);
        write_rec(mkrec(8'h30));
        write_rec(mkrec(8'h31));
        chk("mid_b_fill", 32'(FILL_LEVEL), 32'd2);
        read_words("mid_b", mkrec(8'h30), L, 1'b0, '0);
        read_words("mid_c", mkrec(8'h31), L, 1'b0, '0);
        chk("mid_end_empty", 32'(FIFO_EMPTY), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
